// File: rtl/gray_pkg.sv
// Shared encodings and the Gray step sequence for the step controller.
package gray_pkg;

    typedef enum logic [1:0] {
        CMD_STEP_N      = 2'b00,
        CMD_RUN_TO_WRAP = 2'b01,
        CMD_CLEAR       = 2'b10,
        CMD_ILLEGAL     = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_WRAP = 2'd2
    } state_e;

    localparam int unsigned CODE_W    = 3;
    localparam logic [2:0]  GRAY_LAST = 3'b100;

    // Successor in 000-001-011-010-110-111-101-100 order; 100 returns to 000.
    function automatic logic [2:0] gray_next(input logic [2:0] code);
        case (code)
            3'b000:  gray_next = 3'b001;
            3'b001:  gray_next = 3'b011;
            3'b011:  gray_next = 3'b010;
            3'b010:  gray_next = 3'b110;
            3'b110:  gray_next = 3'b111;
            3'b111:  gray_next = 3'b101;
            3'b101:  gray_next = 3'b100;
            default: gray_next = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/gray_step_ctrl_if.sv
// Host command / status bundle for gray_step_ctrl.
interface gray_step_ctrl_if
    import gray_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) ();

    logic               Start;
    cmd_e               Cmd;
    logic [CNT_W-1:0]   Steps;
    logic               Stop;
    logic               Busy;
    logic               Done;
    logic               Aborted;
    logic               Error;
    logic [CODE_W-1:0]  Code;
    logic               Wrapped;
    logic [CNT_W-1:0]   WrapCount;

    modport master (
        output Start, Cmd, Steps, Stop,
        input  Busy, Done, Aborted, Error, Code, Wrapped, WrapCount
    );

    modport slave (
        input  Start, Cmd, Steps, Stop,
        output Busy, Done, Aborted, Error, Code, Wrapped, WrapCount
    );

endinterface

// File: rtl/gray_core.sv
// 3-bit Gray step register; Wrap flags the advance out of the last code.
module gray_core
    import gray_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              En,
    input  logic              Clr,
    output logic [CODE_W-1:0] Code,
    output logic              Wrap
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Code <= 3'b000;
        end else if (Clr) begin
            Code <= 3'b000;
        end else if (En) begin
            Code <= gray_next(Code);
        end
    end

    assign Wrap = En && (Code == GRAY_LAST);

endmodule

// File: rtl/gray_step_ctrl.sv
// Command sequencer for the Gray step counter: STEP_N, RUN_TO_WRAP, CLEAR,
// with wrap tracking and a Busy/Done completion handshake.
module gray_step_ctrl
    import gray_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    gray_step_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               busy_q, done_q, aborted_q, error_q;
    logic               done_d, aborted_d, error_d;
    logic               wrapped_q;
    logic [CNT_W-1:0]   wrap_cnt_q;
    logic               en_c, clr_c, wrap_c;
    logic [CODE_W-1:0]  code;

    gray_core u_core (
        .Clk   (Clk),
        .Reset (Reset),
        .En    (en_c),
        .Clr   (clr_c),
        .Code  (code),
        .Wrap  (wrap_c)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= done_d;
            aborted_q <= aborted_d;
            error_q   <= error_d;
        end
    end

    // Next state, counter enable and completion pulses.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        en_c      = 1'b0;
        clr_c     = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        error_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    case (bus.Cmd)
                        CMD_STEP_N: begin
                            if (bus.Steps != '0) begin
                                rem_d   = bus.Steps;
                                state_d = ST_STEP;
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                        CMD_RUN_TO_WRAP: state_d = ST_WRAP;
                        CMD_CLEAR: begin
                            clr_c  = 1'b1;
                            done_d = 1'b1;
                        end
                        default: begin
                            done_d  = 1'b1;
                            error_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_STEP: begin
                if (bus.Stop) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else begin
                    en_c  = 1'b1;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_WRAP: begin
                if (bus.Stop) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else begin
                    en_c = 1'b1;
                    if (code == GRAY_LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky wrap flag and saturating wrap counter.
    always_ff @(posedge Clk) begin
        if (Reset || clr_c) begin
            wrapped_q  <= 1'b0;
            wrap_cnt_q <= '0;
        end else if (wrap_c) begin
            wrapped_q <= 1'b1;
            if (wrap_cnt_q != CNT_MAX) begin
                wrap_cnt_q <= wrap_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Aborted   = aborted_q;
    assign bus.Error     = error_q;
    assign bus.Code      = code;
    assign bus.Wrapped   = wrapped_q;
    assign bus.WrapCount = wrap_cnt_q;

endmodule

// File: tb/tb_gray_step_ctrl.sv
// Directed bench for gray_step_ctrl: vector table plus hand sequences.
module tb_gray_step_ctrl;
    import gray_pkg::*;

    logic Clk;
    logic Reset;
    int   checks;
    int   errors;

    gray_step_ctrl_if #(.CNT_W(8)) bus8 ();
    gray_step_ctrl_if #(.CNT_W(2)) bus2 ();

    gray_step_ctrl #(.CNT_W(8)) dut8 (.Clk(Clk), .Reset(Reset), .bus(bus8.slave));
    gray_step_ctrl #(.CNT_W(2)) dut2 (.Clk(Clk), .Reset(Reset), .bus(bus2.slave));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       start;
        cmd_e       cmd;
        logic [7:0] steps;
        logic       stop;
        logic       busy;
        logic       done;
        logic       aborted;
        logic       error;
        logic [2:0] code;
        logic       wrapped;
        logic [7:0] wcnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input cmd_e c, input logic [7:0] n, input logic sp,
                       input logic b, input logic d, input logic a, input logic e,
                       input logic [2:0] cd, input logic w, input logic [7:0] wc);
        vec_t v;
        v.start = st; v.cmd = c; v.steps = n; v.stop = sp;
        v.busy = b; v.done = d; v.aborted = a; v.error = e;
        v.code = cd; v.wrapped = w; v.wcnt = wc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle8();
        bus8.Start = 1'b0; bus8.Cmd = CMD_STEP_N; bus8.Steps = 8'd0; bus8.Stop = 1'b0;
    endtask

    task automatic chk8(input string tag, input logic b, input logic d, input logic a,
                        input logic e, input logic [2:0] cd, input logic w, input logic [7:0] wc);
        chk({tag, ".busy"},    32'(bus8.Busy),      32'(b));
        chk({tag, ".done"},    32'(bus8.Done),      32'(d));
        chk({tag, ".aborted"}, 32'(bus8.Aborted),   32'(a));
        chk({tag, ".error"},   32'(bus8.Error),     32'(e));
        chk({tag, ".code"},    32'(bus8.Code),      32'(cd));
        chk({tag, ".wrapped"}, 32'(bus8.Wrapped),   32'(w));
        chk({tag, ".wcnt"},    32'(bus8.WrapCount), 32'(wc));
    endtask

    initial begin
        int   cyc;
        logic seen;
        checks = 0;
        errors = 0;
        Reset  = 1'b1;
        idle8();
        bus2.Start = 1'b0; bus2.Cmd = CMD_STEP_N; bus2.Steps = 2'd0; bus2.Stop = 1'b0;

        //        st  cmd              n    sp  busy done ab er code    wr wcnt
        add(1'b1, CMD_STEP_N,      8'd3,  1'b0, 1, 0, 0, 0, 3'b000, 0, 8'd0);
        add(1'b0, CMD_STEP_N,      8'd0,  1'b0, 1, 0, 0, 0, 3'b001, 0, 8'd0);
        add(1'b0, CMD_STEP_N,      8'd0,  1'b0, 1, 0, 0, 0, 3'b011, 0, 8'd0);
        add(1'b0, CMD_STEP_N,      8'd0,  1'b0, 0, 1, 0, 0, 3'b010, 0, 8'd0);
        add(1'b1, CMD_RUN_TO_WRAP, 8'd0,  1'b0, 1, 0, 0, 0, 3'b010, 0, 8'd0);
        add(1'b0, CMD_STEP_N,      8'd0,  1'b0, 1, 0, 0, 0, 3'b110, 0, 8'd0);
        add(1'b0, CMD_STEP_N,      8'd0,  1'b0, 1, 0, 0, 0, 3'b111, 0, 8'd0);
        add(1'b0, CMD_STEP_N,      8'd0,  1'b0, 1, 0, 0, 0, 3'b101, 0, 8'd0);
        add(1'b0, CMD_STEP_N,      8'd0,  1'b0, 1, 0, 0, 0, 3'b100, 0, 8'd0);
        add(1'b0, CMD_STEP_N,      8'd0,  1'b0, 0, 1, 0, 0, 3'b000, 1, 8'd1);
        add(1'b0, CMD_STEP_N,      8'd0,  1'b0, 0, 0, 0, 0, 3'b000, 1, 8'd1);
        add(1'b1, CMD_STEP_N,      8'd20, 1'b0, 1, 0, 0, 0, 3'b000, 1, 8'd1);
        add(1'b1, CMD_RUN_TO_WRAP, 8'd0,  1'b0, 1, 0, 0, 0, 3'b001, 1, 8'd1);
        add(1'b0, CMD_STEP_N,      8'd0,  1'b0, 1, 0, 0, 0, 3'b011, 1, 8'd1);
        add(1'b1, CMD_CLEAR,       8'd0,  1'b0, 1, 0, 0, 0, 3'b010, 1, 8'd1);
        add(1'b0, CMD_STEP_N,      8'd0,  1'b1, 0, 1, 1, 0, 3'b010, 1, 8'd1);
        add(1'b0, CMD_STEP_N,      8'd0,  1'b1, 0, 0, 0, 0, 3'b010, 1, 8'd1);
        add(1'b1, CMD_ILLEGAL,     8'd0,  1'b1, 0, 1, 0, 1, 3'b010, 1, 8'd1);
        add(1'b1, CMD_STEP_N,      8'd0,  1'b0, 0, 1, 0, 0, 3'b010, 1, 8'd1);
        add(1'b1, CMD_CLEAR,       8'd0,  1'b0, 0, 1, 0, 0, 3'b000, 0, 8'd0);
        add(1'b0, CMD_STEP_N,      8'd0,  1'b0, 0, 0, 0, 0, 3'b000, 0, 8'd0);
        add(1'b1, CMD_STEP_N,      8'd1,  1'b1, 1, 0, 0, 0, 3'b000, 0, 8'd0);
        add(1'b0, CMD_STEP_N,      8'd0,  1'b0, 0, 1, 0, 0, 3'b001, 0, 8'd0);

        tick();
        tick();
        chk8("reset", 0, 0, 0, 0, 3'b000, 0, 8'd0);
        chk("reset.dut2.wcnt", 32'(bus2.WrapCount), 32'd0);
        Reset = 1'b0;

        foreach (vecs[i]) begin
            bus8.Start = vecs[i].start;
            bus8.Cmd   = vecs[i].cmd;
            bus8.Steps = vecs[i].steps;
            bus8.Stop  = vecs[i].stop;
            tick();
            chk8($sformatf("vec%0d", i), vecs[i].busy, vecs[i].done, vecs[i].aborted,
                 vecs[i].error, vecs[i].code, vecs[i].wrapped, vecs[i].wcnt);
        end
        idle8();

        // RUN_TO_WRAP from 001 runs seven advances to 000
        bus8.Start = 1'b1; bus8.Cmd = CMD_RUN_TO_WRAP;
        tick();
        idle8();
        seen = 1'b0;
        cyc  = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            cyc++;
            seen = bus8.Done;
        end
        chk("run.done_seen", 32'(seen), 32'd1);
        chk("run.cycles", 32'(cyc), 32'd7);
        chk8("run.end", 0, 1, 0, 0, 3'b000, 1, 8'd1);

        // Reset in the middle of a RUN_TO_WRAP
        bus8.Start = 1'b1; bus8.Cmd = CMD_RUN_TO_WRAP;
        tick();
        idle8();
        tick();
        tick();
        chk8("midrun", 1, 0, 0, 0, 3'b011, 1, 8'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk8("midreset", 0, 0, 0, 0, 3'b000, 0, 8'd0);
        bus8.Start = 1'b1; bus8.Cmd = CMD_STEP_N; bus8.Steps = 8'd2;
        tick();
        idle8();
        chk8("post.acc", 1, 0, 0, 0, 3'b000, 0, 8'd0);
        tick();
        chk8("post.s1", 1, 0, 0, 0, 3'b001, 0, 8'd0);
        tick();
        chk8("post.s2", 0, 1, 0, 0, 3'b011, 0, 8'd0);

        // Narrow instance: wrap counter saturates at 3
        for (int r = 0; r < 4; r++) begin
            bus2.Start = 1'b1; bus2.Cmd = CMD_RUN_TO_WRAP;
            tick();
            bus2.Start = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 16 && !seen; k++) begin
                tick();
                seen = bus2.Done;
            end
            chk($sformatf("sat%0d.done_seen", r), 32'(seen), 32'd1);
            chk($sformatf("sat%0d.wcnt", r), 32'(bus2.WrapCount), (r < 3) ? 32'(r + 1) : 32'd3);
            chk($sformatf("sat%0d.code", r), 32'(bus2.Code), 32'd0);
        end
        chk("sat.wrapped", 32'(bus2.Wrapped), 32'd1);
        bus2.Start = 1'b1; bus2.Cmd = CMD_CLEAR;
        tick();
        bus2.Start = 1'b0;
        chk("clr.done", 32'(bus2.Done), 32'd1);
        chk("clr.busy", 32'(bus2.Busy), 32'd0);
        chk("clr.wrapped", 32'(bus2.Wrapped), 32'd0);
        chk("clr.wcnt", 32'(bus2.WrapCount), 32'd0);
        chk("clr.code", 32'(bus2.Code), 32'd0);
        tick();
        chk("clr.done_low", 32'(bus2.Done), 32'd0);
        chk("clr.busy_low", 32'(bus2.Busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
